// File: rtl/mmu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmu_ctrl_pkg                                                 |
// | Description : Shared definitions for the MMU chain tile sequencer: state   |
// |               encoding, segment-count and address-width helpers, default   |
// |               row width and pipeline latency.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mmu_ctrl_pkg;

  localparam int DEF_ROW_W    = 16;
  localparam int DEF_PIPE_LAT = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WLOAD   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Bits needed to address 0..value-1; never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Number of MMU segments along the chain.
  function automatic int seg_count(input int size, input int blk);
    return size / blk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_chain_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mmu_chain_ctrl_if                                            |
// | Description : Tile request/config from the layer scheduler plus the chain  |
// |               control, buffer read and writeback signals of the sequencer. |
// |               slave  : sequencer view (takes start/cfg, drives the rest)   |
// |               master : scheduler/environment view                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mmu_chain_ctrl_if #(
  parameter int S_LEN = 8,
  parameter int ROW_W = 16,
  parameter int WT_AW = 7
);
  logic             start;
  logic [ROW_W-1:0] cfg_rows;
  logic [S_LEN-1:0] cfg_inject_mask;
  logic [S_LEN-1:0] cfg_acc_clr_mask;
  logic             busy;
  logic             done;
  logic             mmu_control;
  logic [S_LEN-1:0] data_sle_s;
  logic [S_LEN-1:0] acc_sle_d;
  logic             wt_rd_en;
  logic [WT_AW-1:0] wt_rd_addr;
  logic             data_rd_en;
  logic [ROW_W-1:0] data_rd_addr;
  logic             acc_valid;
  logic [ROW_W-1:0] acc_wr_addr;

  modport slave (
    input  start, cfg_rows, cfg_inject_mask, cfg_acc_clr_mask,
    output busy, done, mmu_control, data_sle_s, acc_sle_d,
           wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr,
           acc_valid, acc_wr_addr
  );

  modport master (
    output start, cfg_rows, cfg_inject_mask, cfg_acc_clr_mask,
    input  busy, done, mmu_control, data_sle_s, acc_sle_d,
           wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr,
           acc_valid, acc_wr_addr
  );
endinterface
`default_nettype wire

// File: rtl/mmu_ctrl_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmu_ctrl_delay                                               |
// | Description : Valid+data shift register of DEPTH stages with synchronous   |
// |               clear. Data advances only alongside a valid bit, so the      |
// |               output data holds its last valid value across bubbles.       |
// | Ports       : clk, rst            - clock, synchronous active-high clear   |
// |               in_valid, in_data   - stage input                            |
// |               out_valid, out_data - input delayed by DEPTH cycles          |
// |               any_valid           - something is still in flight that has  |
// |                                     not yet reached the output stage       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmu_ctrl_delay #(
  parameter int DEPTH = 256,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         any_valid
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         v_in;
    logic [W-1:0] d_in;
    logic         v_q;
    logic [W-1:0] d_q;
    // OR of the line input and every stage upstream of this one.
    logic         ahead;

    if (i == 0) begin : g_head
      assign v_in  = in_valid;
      assign d_in  = in_data;
      assign ahead = in_valid;
    end else begin : g_tail
      assign v_in  = g_stage[i-1].v_q;
      assign d_in  = g_stage[i-1].d_q;
      assign ahead = g_stage[i-1].ahead | g_stage[i-1].v_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_in;
        if (v_in) begin
          d_q <= d_in;
        end
      end
    end
  end

  assign out_valid = g_stage[DEPTH-1].v_q;
  assign out_data  = g_stage[DEPTH-1].d_q;
  // Excludes the output stage: once only the output stage is valid, the
  // final result is being presented and the sequencer may leave DRAIN.
  assign any_valid = g_stage[DEPTH-1].ahead;

endmodule
`default_nettype wire

// File: rtl/mmu_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmu_chain_ctrl                                               |
// | Description : Tile sequencer for the MMU chain systolic datapath. Per tile |
// |               it preloads weights (size cycles), streams activation rows   |
// |               with per-segment inject/acc-clear selects, then drains the   |
// |               pipeline until the last result row has been presented.       |
// | Ports       : clk, rst - clock, synchronous active-high reset              |
// |               bus      - mmu_chain_ctrl_if.slave (start/cfg in; chain      |
// |                          control, buffer reads, writeback stream out)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmu_chain_ctrl
  import mmu_ctrl_pkg::*;
#(
  parameter int size      = 128,
  parameter int mmu_block = 16,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int PIPE_LAT  = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  mmu_chain_ctrl_if.slave  bus
);

  localparam int s_len = seg_count(size, mmu_block);
  localparam int WT_AW = clog2_min1(size);

  state_t           state_q, state_n;
  logic [ROW_W-1:0] rows_q;
  logic [s_len-1:0] inject_q, clr_q;
  logic             cfg_load;

  logic [WT_AW-1:0] wt_addr_q, wt_addr_n;
  logic [ROW_W-1:0] data_addr_q, data_addr_n;
  logic             busy_q, done_q, mctl_q, wt_en_q, data_en_q;
  logic [s_len-1:0] data_sle_q, acc_sle_q;

  logic             in_flight;
  logic             acc_valid_w;
  logic [ROW_W-1:0] acc_addr_w;

  // Next-state and next-address logic; the registered outputs below are
  // decoded from state_n so they change on the same edge as the state.
  always_comb begin
    state_n     = state_q;
    wt_addr_n   = wt_addr_q;
    data_addr_n = data_addr_q;
    cfg_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_n   = ST_WLOAD;
          wt_addr_n = '0;
          cfg_load  = 1'b1;
        end
      end
      ST_WLOAD: begin
        if (wt_addr_q == WT_AW'(size - 1)) begin
          if (rows_q == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n     = ST_COMPUTE;
            data_addr_n = '0;
          end
        end else begin
          wt_addr_n = wt_addr_q + WT_AW'(1);
        end
      end
      ST_COMPUTE: begin
        if (data_addr_q == rows_q - ROW_W'(1)) begin
          state_n = ST_DRAIN;
        end else begin
          data_addr_n = data_addr_q + ROW_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!in_flight) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q      <= '0;
      inject_q    <= '0;
      clr_q       <= '0;
      wt_addr_q   <= '0;
      data_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mctl_q      <= 1'b0;
      wt_en_q     <= 1'b0;
      data_en_q   <= 1'b0;
      data_sle_q  <= '0;
      acc_sle_q   <= '1;
    end else begin
      if (cfg_load) begin
        rows_q   <= bus.cfg_rows;
        inject_q <= bus.cfg_inject_mask;
        clr_q    <= bus.cfg_acc_clr_mask;
      end
      wt_addr_q   <= wt_addr_n;
      data_addr_q <= data_addr_n;
      busy_q      <= (state_n != ST_IDLE);
      done_q      <= (state_n == ST_DONE);
      mctl_q      <= (state_n == ST_WLOAD);
      wt_en_q     <= (state_n == ST_WLOAD);
      data_en_q   <= (state_n == ST_COMPUTE);
      if ((state_n == ST_COMPUTE) || (state_n == ST_DRAIN)) begin
        // Segment 0 has no upstream neighbour, so it always injects.
        data_sle_q <= inject_q | s_len'(1);
        acc_sle_q  <= clr_q;
      end else begin
        data_sle_q <= '0;
        acc_sle_q  <= '1;
      end
    end
  end

  mmu_ctrl_delay #(
    .DEPTH (PIPE_LAT),
    .W     (ROW_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (data_en_q),
    .in_data   (data_addr_q),
    .out_valid (acc_valid_w),
    .out_data  (acc_addr_w),
    .any_valid (in_flight)
  );

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mmu_control  = mctl_q;
  assign bus.data_sle_s   = data_sle_q;
  assign bus.acc_sle_d    = acc_sle_q;
  assign bus.wt_rd_en     = wt_en_q;
  assign bus.wt_rd_addr   = wt_addr_q;
  assign bus.data_rd_en   = data_en_q;
  assign bus.data_rd_addr = data_addr_q;
  assign bus.acc_valid    = acc_valid_w;
  assign bus.acc_wr_addr  = acc_addr_w;

endmodule
`default_nettype wire

// File: tb/tb_mmu_chain_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmu_chain_ctrl                                            |
// | Description : Self-checking bench for mmu_chain_ctrl (size=32,             |
// |               mmu_block=16, PIPE_LAT=4). A tile-timeline reference model   |
// |               predicts every output from the cycle offset within a tile.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mmu_chain_ctrl;

  localparam int SIZE  = 32;
  localparam int BLK   = 16;
  localparam int LAT   = 4;
  localparam int ROW_W = 16;
  localparam int S_LEN = SIZE / BLK;
  localparam int WT_AW = 5;

  logic clk;
  logic rst;

  mmu_chain_ctrl_if #(.S_LEN(S_LEN), .ROW_W(ROW_W), .WT_AW(WT_AW)) bus ();

  mmu_chain_ctrl #(
    .size      (SIZE),
    .mmu_block (BLK),
    .ROW_W     (ROW_W),
    .PIPE_LAT  (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  // Reference model: tile offset k counts cycles since the accepting edge.
  bit m_active;
  int m_k;
  int m_rows;
  int m_inj;
  int m_clr;
  int h_wt, h_data, h_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int done_k();
    return (m_rows == 0) ? SIZE + 1 : SIZE + m_rows + LAT + 1;
  endfunction

  function automatic bit in_wload();
    return m_active && (m_k <= SIZE);
  endfunction

  function automatic bit in_comp();
    return m_active && (m_rows > 0) && (m_k > SIZE) && (m_k <= SIZE + m_rows);
  endfunction

  function automatic bit in_accv();
    return m_active && (m_rows > 0) && (m_k > SIZE + LAT) && (m_k <= SIZE + m_rows + LAT);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_k      = 0;
      h_wt     = 0;
      h_data   = 0;
      h_acc    = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k > done_k()) m_active = 1'b0;
    end else if (bus.start) begin
      m_active = 1'b1;
      m_k      = 1;
      m_rows   = int'(bus.cfg_rows);
      m_inj    = int'(bus.cfg_inject_mask);
      m_clr    = int'(bus.cfg_acc_clr_mask);
    end
    if (in_wload()) h_wt   = m_k - 1;
    if (in_comp())  h_data = m_k - SIZE - 1;
    if (in_accv())  h_acc  = m_k - SIZE - LAT - 1;
  endtask

  task automatic compare_all();
    bit ph;
    ph = m_active && (m_rows > 0) && (m_k > SIZE) && (m_k < done_k());
    check_eq("busy",         bus.busy,         m_active);
    check_eq("done",         bus.done,         m_active && (m_k == done_k()));
    check_eq("mmu_control",  bus.mmu_control,  in_wload());
    check_eq("wt_rd_en",     bus.wt_rd_en,     in_wload());
    check_eq("wt_rd_addr",   bus.wt_rd_addr,   h_wt);
    check_eq("data_rd_en",   bus.data_rd_en,   in_comp());
    check_eq("data_rd_addr", bus.data_rd_addr, h_data);
    check_eq("acc_valid",    bus.acc_valid,    in_accv());
    check_eq("acc_wr_addr",  bus.acc_wr_addr,  h_acc);
    check_eq("data_sle_s",   bus.data_sle_s,   ph ? ((m_inj | 1) & 3) : 0);
    check_eq("acc_sle_d",    bus.acc_sle_d,    ph ? m_clr : 3);
    if (bus.done) n_done++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic start_tile(input int rows, input int inj, input int clr);
    bus.cfg_rows         = ROW_W'(rows);
    bus.cfg_inject_mask  = S_LEN'(inj);
    bus.cfg_acc_clr_mask = S_LEN'(clr);
    bus.start            = 1'b1;
    step();
    bus.start            = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (m_active && n < max_cycles) begin
      step();
      n++;
    end
    step();
    check_eq(tag, bus.busy, 1'b0);
  endtask

  initial begin
    int d0;
    m_active = 1'b0; m_k = 0; m_rows = 0; m_inj = 0; m_clr = 0;
    h_wt = 0; h_data = 0; h_acc = 0;
    rst                  = 1'b1;
    bus.start            = 1'b0;
    bus.cfg_rows         = '0;
    bus.cfg_inject_mask  = '0;
    bus.cfg_acc_clr_mask = '0;

    // Reset held for three cycles.
    repeat (3) step();
    check_eq("reset_acc_sle_d", bus.acc_sle_d, 2'b11);
    rst = 1'b0;
    step();

    // Nominal tile: rows=4, inject=00, clr=11.
    start_tile(4, 0, 3);
    run_to_idle("nominal_end", 200);

    // rows=0: weight load only.
    start_tile(0, 1, 2);
    run_to_idle("rows0_end", 200);

    // start pulsed while computing is ignored.
    d0 = n_done;
    start_tile(6, 2, 1);
    while (m_active && m_k < SIZE + 3) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_to_idle("ignore_start_end", 200);
    check_eq("ignore_start_done_count", n_done - d0, 1);

    // Reset in the middle of COMPUTE: flush, no done pulse.
    d0 = n_done;
    start_tile(8, 3, 0);
    while (m_active && m_k < 35) step();
    rst = 1'b1;
    step();
    check_eq("midrst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    repeat (12) step();
    check_eq("midrst_no_done", n_done - d0, 0);

    // Non-trivial masks: inject=10, clr=01.
    start_tile(3, 2, 1);
    run_to_idle("mask_end", 200);
    check_eq("mask_idle_sle", bus.data_sle_s, 2'b00);
    check_eq("mask_idle_acc", bus.acc_sle_d, 2'b11);

    // Random traffic: sporadic starts in every state, config churn, rare resets.
    for (int i = 0; i < 2500; i++) begin
      rst                  = ($urandom_range(0, 399) == 0);
      bus.start            = ($urandom_range(0, 11) == 0);
      bus.cfg_rows         = ROW_W'($urandom_range(0, 10));
      bus.cfg_inject_mask  = S_LEN'($urandom_range(0, 3));
      bus.cfg_acc_clr_mask = S_LEN'($urandom_range(0, 3));
      step();
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    run_to_idle("random_end", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
